// File: rtl/wfetch_pkg.sv
// Shared types and constants for the fully-connected layer weight fetcher.
package wfetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN
   } state_e;

   localparam int WORD_BYTES         = 4;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   // Byte address of the following weight word; wraps modulo 2^32.
   function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
      return addr + 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/wfetch_fifo.sv
// Synchronous first-word-fall-through buffer between the weight BRAM and the MAC array.
// Simultaneous push and pop are both honoured; dout reads 0 while empty.
module wfetch_fifo
   import wfetch_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   // NOTE: sequential state uses <= so every register sees pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fc_weight_fetch.sv
// Streams a burst of 32-bit weight words from a BRAM to the MAC array with credit-based flow control.
// Define FC_WEIGHT_FETCH_PERF_EN to add the stall_cnt back-pressure counter output.
module fc_weight_fetch
   import wfetch_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] num_words,
   output logic             busy,
   output logic             done,
   output logic [31:0]      bram_addr,
   output logic             bram_en,
   output logic [3:0]       bram_wen,
   output logic [31:0]      bram_din,
   input  logic [31:0]      bram_dout,
   output logic [31:0]      w_data,
   output logic             w_valid,
   input  logic             w_ready
`ifdef FC_WEIGHT_FETCH_PERF_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = CNT_W + 2;

   state_e           state;
   state_e           state_d;
   logic [LEN_W-1:0] remaining;
   logic             rd_pend;
   logic             zero_done;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             pop;
   logic             start_ok;
   logic             start_zero;
   logic             issue_next;
   logic [SUM_W-1:0] credit_used;

   assign bram_wen = 4'b0000;
   assign bram_din = '0;

   assign w_valid    = !fifo_empty;
   assign pop        = w_valid && w_ready;
   assign start_ok   = (state == ST_IDLE) && start && (num_words != '0);
   assign start_zero = (state == ST_IDLE) && start && (num_words == '0);

   // Slots committed next cycle: FIFO level after this cycle's push/pop plus the read on the port now.
   assign credit_used = SUM_W'(fifo_count) + SUM_W'(rd_pend) + SUM_W'(bram_en) - SUM_W'(pop);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state;
      issue_next = 1'b0;
      busy       = 1'b0;
      done       = zero_done;
      case (state)
         ST_IDLE: begin
            if (start_ok) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            busy = 1'b1;
            if (remaining == '0) begin
               state_d = ST_DRAIN;
            end else if (credit_used < SUM_W'(FIFO_DEPTH)) begin
               issue_next = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && !rd_pend) begin
               state_d = ST_IDLE;
               done    = 1'b1;
            end else begin
               busy = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The first read goes out straight from IDLE so bram_en appears the cycle after start.
   always_ff @(posedge clk) begin
      if (rst) begin
         bram_en   <= 1'b0;
         bram_addr <= '0;
         remaining <= '0;
         rd_pend   <= 1'b0;
         zero_done <= 1'b0;
      end else begin
         rd_pend   <= bram_en;
         zero_done <= start_zero;
         bram_en   <= 1'b0;
         if (start_ok) begin
            bram_en   <= 1'b1;
            bram_addr <= base_addr & 32'hFFFF_FFFC;
            remaining <= num_words - LEN_W'(1);
         end else if (issue_next) begin
            bram_en   <= 1'b1;
            bram_addr <= next_word_addr(bram_addr);
            remaining <= remaining - LEN_W'(1);
         end
      end
   end

   wfetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_pend),
      .din   (bram_dout),
      .pop   (pop),
      .dout  (w_data),
      .count (fifo_count),
      .empty (fifo_empty)
   );

`ifdef FC_WEIGHT_FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || ((state == ST_IDLE) && start)) begin
         stall_cnt <= '0;
      end else if (w_valid && !w_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fc_weight_fetch.sv
// Scoreboard bench for fc_weight_fetch: expected words queued at start, popped on each transfer.
module tb_fc_weight_fetch;

   localparam int DEPTH = 4;
   localparam int LEN_W = 16;
   localparam int MAX_CYC = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      base_addr;
   logic [LEN_W-1:0] num_words;
   logic             busy;
   logic             done;
   logic [31:0]      bram_addr;
   logic             bram_en;
   logic [3:0]       bram_wen;
   logic [31:0]      bram_din;
   logic [31:0]      bram_dout;
   logic [31:0]      w_data;
   logic             w_valid;
   logic             w_ready;
`ifdef FC_WEIGHT_FETCH_PERF_EN
   logic [31:0]      stall_cnt;
`endif

   always #5 clk = ~clk;

   fc_weight_fetch #(
      .FIFO_DEPTH (DEPTH),
      .LEN_W      (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .bram_addr (bram_addr),
      .bram_en   (bram_en),
      .bram_wen  (bram_wen),
      .bram_din  (bram_din),
      .bram_dout (bram_dout),
      .w_data    (w_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready)
`ifdef FC_WEIGHT_FETCH_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // BRAM preloaded with mem[i] = 0x1000_0000 + i; garbage when not enabled.
   always @(posedge clk) begin
      bram_dout <= bram_en ? (32'h1000_0000 + (bram_addr >> 2)) : 32'hDEAD_BEEF;
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];
   int          rel, slo, shi, rst_at, restart_at;
   int          issued, delivered, reads, first_rd, last_rd, first_valid, last_xfer;
   int          done_cyc, done_cnt;
   logic        busy_seen, busy_at_done, prev_stall;
   logic [31:0] exp_addr, prev_data, stall_data;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, rel);
      end
   endtask

   task automatic monitor();
      if (bram_en) begin
         if (first_rd < 0) first_rd = rel;
         last_rd = rel;
         reads++;
         issued++;
         check("rd_addr", bram_addr, exp_addr);
         exp_addr = exp_addr + 32'd4;
         check("outstanding_bound", 32'(issued - delivered <= DEPTH), 32'd1);
      end
      if (prev_stall) begin
         check("hold_valid", 32'(w_valid), 32'd1);
         check("hold_data", w_data, prev_data);
      end
      if (w_valid && first_valid < 0) first_valid = rel;
      if (w_valid && rel == slo) stall_data = w_data;
      if (w_valid && w_ready) begin
         if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 32'd1);
         else                   check("w_data", w_data, exp_q.pop_front());
         delivered++;
         last_xfer = rel;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin
         done_cnt++;
         done_cyc     = rel;
         busy_at_done = busy;
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
   endtask

   task automatic step();
      @(negedge clk);
      rel++;
      w_ready = !(rel >= slo && rel <= shi);
      start   = (rel == restart_at);
      rst     = (rel == rst_at);
      monitor();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start   = 1'b0;
         rst     = 1'b0;
         w_ready = 1'b1;
      end
   endtask

   // Call at a negedge with the DUT idle; that cycle is cycle 0 (start high).
   task automatic run_burst(input logic [31:0] base, input int nw, input int lo, input int hi,
                            input int rst_c, input int restart_c);
      logic [31:0] aligned;
      bit          fin;
      aligned = base & 32'hFFFF_FFFC;
      exp_q.delete();
      for (int i = 0; i < nw; i++) exp_q.push_back(32'h1000_0000 + ((aligned + 32'(4 * i)) >> 2));
      exp_addr = aligned;
      issued = 0; delivered = 0; reads = 0;
      first_rd = -1; last_rd = -1; first_valid = -1; last_xfer = -1;
      done_cyc = -1; done_cnt = 0;
      busy_seen = 1'b0; busy_at_done = 1'b0; prev_stall = 1'b0;
      prev_data = '0; stall_data = '0;
      slo = lo; shi = hi; rst_at = rst_c; restart_at = restart_c;
      rel       = 0;
      base_addr = base;
      num_words = LEN_W'(nw);
      start     = 1'b1;
      rst       = 1'b0;
      w_ready   = 1'b1;
      monitor();
      fin = 1'b0;
      while (!fin) begin
         step();
         if (rel == 1) begin
            base_addr = 32'h0000_0200;
            num_words = LEN_W'(3);
         end
         if (rst_c >= 0 && rel == rst_c + 1) begin
            fin = 1'b1;
         end else if (done_cnt > 0) begin
            fin = 1'b1;
            check("words_left", 32'(exp_q.size()), 32'd0);
         end else if (rel >= MAX_CYC) begin
            fin = 1'b1;
            check("burst_timeout", 32'(done_cnt), 32'd1);
         end
      end
      start   = 1'b0;
      w_ready = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; w_ready = 1'b1;
      rel = 0; slo = -1; shi = -1; rst_at = -1; restart_at = -1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bram_en", 32'(bram_en), 32'd0);
      check("rst_bram_addr", bram_addr, 32'd0);
      check("rst_w_valid", 32'(w_valid), 32'd0);
      check("rst_w_data", w_data, 32'd0);
      check("bram_wen_tied", 32'(bram_wen), 32'd0);
      check("bram_din_tied", bram_din, 32'd0);
`ifdef FC_WEIGHT_FETCH_PERF_EN
      check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
      rst = 1'b0;
      idle(1);

      // Basic 5-word burst with full throughput.
      run_burst(32'h10, 5, -1, -1, -1, -1);
      check("b5_first_rd", 32'(first_rd), 32'd1);
      check("b5_last_rd", 32'(last_rd), 32'd5);
      check("b5_reads", 32'(reads), 32'd5);
      check("b5_first_valid", 32'(first_valid), 32'd3);
      check("b5_last_xfer", 32'(last_xfer), 32'd7);
      check("b5_done_cyc", 32'(done_cyc), 32'd8);
      check("b5_busy_at_done", 32'(busy_at_done), 32'd0);
      idle(2);

      // Zero-length request.
      run_burst(32'h80, 0, -1, -1, -1, -1);
      check("z_done_cyc", 32'(done_cyc), 32'd1);
      check("z_reads", 32'(reads), 32'd0);
      check("z_busy_seen", 32'(busy_seen), 32'd0);
      idle(2);

      // Back-pressure: consumer stalls cycles 4-9.
      run_burst(32'h0, 8, 4, 9, -1, -1);
      check("st_held_word", stall_data, 32'h1000_0001);
      check("st_delivered", 32'(delivered), 32'd8);
`ifdef FC_WEIGHT_FETCH_PERF_EN
      check("st_stall_cnt", stall_cnt, 32'd6);
`endif
      idle(2);

      // Address wrap at the top of the 32-bit space.
      run_burst(32'hFFFF_FFFC, 2, -1, -1, -1, -1);
      check("wr_reads", 32'(reads), 32'd2);
      check("wr_delivered", 32'(delivered), 32'd2);
      idle(2);

      // Start while busy is ignored.
      run_burst(32'h10, 5, -1, -1, -1, 3);
      check("rs_done_cyc", 32'(done_cyc), 32'd8);
      check("rs_delivered", 32'(delivered), 32'd5);
      check("rs_reads", 32'(reads), 32'd5);
      idle(2);

      // Unaligned base and a single-word burst.
      run_burst(32'h23, 3, -1, -1, -1, -1);
      check("ua_delivered", 32'(delivered), 32'd3);
      idle(2);
      run_burst(32'h8, 1, -1, -1, -1, -1);
      check("one_done_cyc", 32'(done_cyc), 32'd4);
      idle(2);

      // Reset in cycle 4 of a 10-word burst, then a fresh burst.
      run_burst(32'h0, 10, -1, -1, 4, -1);
      check("mr_bram_en", 32'(bram_en), 32'd0);
      check("mr_w_valid", 32'(w_valid), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      idle(1);
      run_burst(32'h40, 4, -1, -1, -1, -1);
      check("mr_first_valid", 32'(first_valid), 32'd3);
      check("mr_delivered", 32'(delivered), 32'd4);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_weight_fetch.md
FC_WEIGHT_FETCH -- requirements
Module: fc_weight_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words; legal minimum 3.
REQ-002 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL provide the following ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a burst.
- base_addr  in  32  byte address of first weight word; bits [1:0] are ignored and treated as 0.
- num_words  in  LEN_W  number of 32-bit words to fetch.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the burst completes.
- bram_addr  out  32  byte address to the weight BRAM.
- bram_en  out  1  BRAM read enable.
- bram_wen  out  4  tied 4'b0000.
- bram_din  out  32  tied 0.
- bram_dout  in  32  BRAM read data, valid one cycle after bram_en.
- w_data  out  32  weight word to the MAC array.
- w_valid  out  1  w_data is valid.
- w_ready  in  1  consumer accepts w_data this cycle.

Function
REQ-005 SHALL implement an FSM with states IDLE, FETCH and DRAIN.
REQ-006 IDLE + start with num_words>0 SHALL latch base_addr and num_words and go to FETCH; busy=1 from the next cycle.
REQ-007 IDLE + start with num_words==0 SHALL pulse done in the next cycle, stay in IDLE, and issue no read.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 FETCH SHALL assert bram_en with bram_addr = base + 4*i for i = 0..num_words-1, in order, one read per cycle at most.
- A read issues only when FIFO occupancy plus in-flight reads < FIFO_DEPTH.
- bram_addr wraps modulo 2^32.
REQ-010 bram_dout SHALL be written into the FIFO in the cycle after its read; bram_en SHALL be 0 on all other cycles.
REQ-011 After issuing the last read, the FSM SHALL go to DRAIN; DRAIN SHALL exit to IDLE when the FIFO is empty and nothing is in flight.
- On that exit, done=1 for one cycle and busy=0 in the same cycle.
REQ-012 Latency: start in cycle 0 -> bram_en in cycle 1 -> first w_valid in cycle 3.
REQ-013 With w_ready held high, the block SHALL sustain one word per cycle.
REQ-014 Handshake: a word transfers when w_valid && w_ready.
- While w_valid=1 and w_ready=0, w_data SHALL hold stable.
- w_valid SHALL NOT drop until the word transfers.
REQ-015 A FIFO push and pop in the same cycle SHALL both take effect; no overflow and no underflow SHALL ever occur.
REQ-016 Words SHALL be delivered exactly once each, in address order.

Reset
REQ-017 On rst, all outputs SHALL reset to 0: busy, done, bram_en, bram_addr, w_valid, w_data, and stall_cnt if present.
REQ-018 On rst, the FSM SHALL go to IDLE.
REQ-019 Reset mid-burst SHALL flush the FIFO and discard any in-flight read; bram_en=0 in the cycle after reset.

Configuration
REQ-020 Macro FC_WEIGHT_FETCH_PERF_EN, when defined, SHALL add output port stall_cnt (32 bits).
- stall_cnt increments every cycle with w_valid && !w_ready, and saturates at 0xFFFFFFFF.
- stall_cnt clears on rst and on an accepted start.
REQ-021 Without FC_WEIGHT_FETCH_PERF_EN, the port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-022 Shared package wfetch_pkg SHALL hold the FSM state enum, WORD_BYTES=4, and the default FIFO depth.
REQ-023 The buffer SHALL be a sub-module wfetch_fifo: synchronous, parameterised depth, with count output.

Verification
All scenarios use a BRAM model preloaded with mem[i] = 32'h1000_0000+i.
REQ-024 base=0x10, num_words=5, w_ready=1:
- bram_en in cycles 1-5 with addresses 0x10, 0x14, 0x18, 0x1C, 0x20.
- w_data 0x10000004..0x10000008 in cycles 3-7.
- done in cycle 8.
REQ-025 num_words=0 -> done in cycle 1, bram_en never asserted, busy stays 0.
REQ-026 base=0, num_words=8, w_ready low cycles 4-9:
- w_data=0x10000001 held stable during the stall.
- No more than FIFO_DEPTH reads outstanding.
- All 8 words arrive in order.
- With the macro defined, stall_cnt=6.
REQ-027 rst in cycle 4 of a 10-word burst:
- Cycle 5: bram_en=0, w_valid=0, busy=0.
- A new start with base=0x40 then yields 0x10000010 first.
REQ-028 base=0xFFFFFFFC, num_words=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-029 start asserted while busy -> ignored; burst word count and done timing unchanged.
